// File: rtl/gin_ingress_fifo.sv
// gin_ingress_fifo: tagged first-word-fall-through ingress FIFO feeding the GIN X-bus master port.
// Define GIN_INGRESS_BYPASS_EN for a zero-latency path through an empty FIFO.
`ifndef XID_BITS
`define XID_BITS 4
`endif
`ifndef DATA_BITS
`define DATA_BITS 8
`endif
module gin_ingress_fifo #(
    parameter int DEPTH   = 4,
    parameter int ID_SIZE = `XID_BITS,
    parameter int DATA_W  = `DATA_BITS
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [ID_SIZE-1:0]         in_tag,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       in_ready,
    output logic [ID_SIZE-1:0]         tag,
    output logic                       master_valid,
    output logic [DATA_W-1:0]          master_data,
    input  logic                       master_ready,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    logic [ID_SIZE+DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic stored_valid, bypass, push, pop;
`ifdef GIN_INGRESS_BYPASS_EN
    assign bypass = ~stored_valid && in_valid && master_ready;
`else
    assign bypass = 1'b0;
`endif
    assign stored_valid = count != '0;
    assign in_ready     = count != CW'(DEPTH);
    assign push         = in_valid && in_ready && !bypass;
    assign pop          = stored_valid && master_ready;
    assign master_valid = stored_valid || bypass;
    // Idle bus sees zeros rather than stale storage.
    assign {tag, master_data} = stored_valid ? mem[rd_ptr] :
                                bypass       ? {in_tag, in_data} : '0;
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {in_tag, in_data};
    end
endmodule

// File: tb/tb_gin_ingress_fifo.sv
// tb_gin_ingress_fifo: directed self-checking bench for gin_ingress_fifo (DEPTH=4, 4-bit tag, 8-bit data).
module tb_gin_ingress_fifo;
    logic       clk = 1'b0;
    logic       rst, flush, in_valid, in_ready, master_valid, master_ready;
    logic [3:0] in_tag, tag;
    logic [7:0] in_data, master_data;
    logic [2:0] count;
    int tests = 0;
    int fails = 0;

    gin_ingress_fifo #(.DEPTH(4), .ID_SIZE(4), .DATA_W(8)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_tag(in_tag),
        .in_data(in_data), .in_ready(in_ready), .tag(tag), .master_valid(master_valid),
        .master_data(master_data), .master_ready(master_ready), .count(count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_tag = 4'h5; in_data = 8'h33; master_ready = 1'b0;
        tick(); tick();
        #1;
        tests++; if (count !== 3'd0) begin fails++; $display("FAIL reset_count got %0d want 0", count); end
        tests++; if (master_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", master_valid); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        tests++; if (tag !== 4'h0) begin fails++; $display("FAIL reset_tag got %h want 0", tag); end
        tests++; if (master_data !== 8'h00) begin fails++; $display("FAIL reset_data got %h want 00", master_data); end
        rst = 1'b0; in_valid = 1'b0;
        tick();
    endtask

    task automatic test_single();
        in_valid = 1'b1; in_tag = 4'h3; in_data = 8'h5A; master_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1;
            tests++; if (master_valid !== 1'b1 || tag !== 4'h3 || master_data !== 8'h5A || count !== 3'd1) begin
                fails++; $display("FAIL single_hold%0d got v=%b t=%h d=%h c=%0d want v=1 t=3 d=5a c=1", i, master_valid, tag, master_data, count);
            end
            tick();
        end
        master_ready = 1'b1;
        tick();
        master_ready = 1'b0;
        #1;
        tests++; if (count !== 3'd0 || master_valid !== 1'b0 || master_data !== 8'h00 || tag !== 4'h0) begin
            fails++; $display("FAIL single_pop got v=%b c=%0d t=%h d=%h want v=0 c=0 t=0 d=00", master_valid, count, tag, master_data);
        end
    endtask

    task automatic test_fill();
        master_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_tag = 4'(i + 1); in_data = 8'(8'h10 + i);
            tick();
        end
        in_valid = 1'b0;
        #1;
        tests++; if (count !== 3'd4) begin fails++; $display("FAIL fill_count got %0d want 4", count); end
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL fill_in_ready got %b want 0", in_ready); end
        in_valid = 1'b1; in_tag = 4'h5; in_data = 8'h14; master_ready = 1'b1;
        #1;
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL full_pop_in_ready got %b want 0", in_ready); end
        tests++; if (master_data !== 8'h10 || tag !== 4'h1) begin fails++; $display("FAIL drain0 got t=%h d=%h want t=1 d=10", tag, master_data); end
        tick();
        in_valid = 1'b0;
        #1;
        tests++; if (count !== 3'd3) begin fails++; $display("FAIL full_refuse_count got %0d want 3", count); end
        for (int i = 1; i < 4; i++) begin
            #1;
            tests++; if (master_valid !== 1'b1 || master_data !== 8'(8'h10 + i) || tag !== 4'(i + 1)) begin
                fails++; $display("FAIL drain%0d got v=%b t=%h d=%h want v=1 t=%h d=%h", i, master_valid, tag, master_data, 4'(i + 1), 8'(8'h10 + i));
            end
            tick();
        end
        master_ready = 1'b0;
        #1;
        tests++; if (count !== 3'd0 || master_valid !== 1'b0) begin fails++; $display("FAIL fill_empty got c=%0d v=%b want c=0 v=0", count, master_valid); end
    endtask

    task automatic test_stream();
        int wi = 0;
        int ri = 0;
        int mcount = 0;
        bit push, pop, byp;
        for (int cyc = 0; cyc < 300 && ri < 20; cyc++) begin
            in_valid = wi < 20; in_tag = 4'(wi); in_data = 8'(wi); master_ready = 1'($urandom_range(0, 1));
            #1;
            byp = 1'b0;
`ifdef GIN_INGRESS_BYPASS_EN
            byp = mcount == 0 && in_valid && master_ready;
`endif
            push = in_valid && in_ready && !byp;
            pop  = master_valid && master_ready;
            if (pop) begin
                tests++; if (master_data !== 8'(ri) || tag !== 4'(ri)) begin
                    fails++; $display("FAIL stream_word%0d got t=%h d=%h want t=%h d=%h", ri, tag, master_data, 4'(ri), 8'(ri));
                end
                ri++;
            end
            if (push || byp) wi++;
            mcount = mcount + int'(push) - int'(pop && !byp);
            tick();
            tests++; if (count !== 3'(mcount) || count > 3'd4) begin
                fails++; $display("FAIL stream_count got %0d want %0d", count, mcount);
            end
        end
        in_valid = 1'b0; master_ready = 1'b0;
        tests++; if (ri !== 20) begin fails++; $display("FAIL stream_delivered got %0d want 20", ri); end
    endtask

    task automatic test_flush();
        master_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_tag = 4'h2; in_data = 8'(8'h20 + i);
            tick();
        end
        #1;
        tests++; if (count !== 3'd3) begin fails++; $display("FAIL flush_pre_count got %0d want 3", count); end
        in_valid = 1'b1; in_data = 8'h23; master_ready = 1'b1; flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0; master_ready = 1'b0;
        #1;
        tests++; if (count !== 3'd0 || master_valid !== 1'b0) begin fails++; $display("FAIL flush_clear got c=%0d v=%b want c=0 v=0", count, master_valid); end
        in_valid = 1'b1; in_tag = 4'hA; in_data = 8'hAA;
        tick();
        in_valid = 1'b0;
        #1;
        tests++; if (master_valid !== 1'b1 || master_data !== 8'hAA || tag !== 4'hA || count !== 3'd1) begin
            fails++; $display("FAIL flush_next got v=%b t=%h d=%h c=%0d want v=1 t=a d=aa c=1", master_valid, tag, master_data, count);
        end
        master_ready = 1'b1;
        tick();
        master_ready = 1'b0;
    endtask

    task automatic test_bypass();
        in_valid = 1'b1; in_tag = 4'h7; in_data = 8'h77; master_ready = 1'b1;
        #1;
`ifdef GIN_INGRESS_BYPASS_EN
        tests++; if (master_valid !== 1'b1 || master_data !== 8'h77 || tag !== 4'h7) begin
            fails++; $display("FAIL bypass_same_cycle got v=%b t=%h d=%h want v=1 t=7 d=77", master_valid, tag, master_data);
        end
        tick();
        in_valid = 1'b0;
        #1;
        tests++; if (count !== 3'd0 || master_valid !== 1'b0) begin fails++; $display("FAIL bypass_after got c=%0d v=%b want c=0 v=0", count, master_valid); end
`else
        tests++; if (master_valid !== 1'b0 || master_data !== 8'h00) begin
            fails++; $display("FAIL nobypass_same_cycle got v=%b d=%h want v=0 d=00", master_valid, master_data);
        end
        tick();
        in_valid = 1'b0;
        #1;
        tests++; if (master_valid !== 1'b1 || master_data !== 8'h77 || tag !== 4'h7 || count !== 3'd1) begin
            fails++; $display("FAIL nobypass_next got v=%b t=%h d=%h c=%0d want v=1 t=7 d=77 c=1", master_valid, tag, master_data, count);
        end
        tick();
        #1;
        tests++; if (count !== 3'd0 || master_valid !== 1'b0) begin fails++; $display("FAIL nobypass_drain got c=%0d v=%b want c=0 v=0", count, master_valid); end
`endif
        master_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_stream();
        test_flush();
        test_bypass();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
